// File: rtl/pwm_frame_loader_pkg.sv
// Shared defaults, reply codes and FSM encoding for the PWM frame loader.
package pwm_frame_loader_pkg;

    localparam int          NUM_CH_DEF      = 11;
    localparam logic [7:0]  SYNC_DEF        = 8'hA5;
    localparam logic [7:0]  ACK             = 8'h06;
    localparam logic [7:0]  NAK             = 8'h15;
    localparam int          TIMEOUT_CYC_DEF = 50000;

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_PAYLOAD = 2'd1;
    localparam logic [1:0]  ST_CHECK   = 2'd2;
    localparam logic [1:0]  ST_REPLY   = 2'd3;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pwm_frame_loader_byte_timer.sv
// Inter-byte / reply-wait watchdog: counts enabled cycles since the last clear.
module byte_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            cnt <= '0;
        else if (enable && cnt != CW'(TIMEOUT_CYC))
            cnt <= cnt + 1'b1;
    end

    assign expired = enable && (cnt == CW'(TIMEOUT_CYC));

endmodule

// File: rtl/pwm_frame_loader.sv
// Parses SYNC + NUM_CH duty bytes + checksum frames, commits duty atomically, replies ACK/NAK.
module pwm_frame_loader
    import pwm_frame_loader_pkg::*;
#(
    parameter int         NUM_CH      = NUM_CH_DEF,
    parameter logic [7:0] SYNC        = SYNC_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                new_rx_data,
    input  logic                tx_busy,
    output logic [7:0]          tx_data,
    output logic                new_tx_data,
    output logic [NUM_CH*8-1:0] duty,
    output logic                duty_valid,
    output logic [7:0]          frame_cnt,
    output logic [7:0]          err_cnt
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [1:0]                 state, state_nxt;
    logic                       rx_prev;
    logic                       byte_ev;
    logic                       expired;
    logic                       tmr_clear;
    logic [IDX_W-1:0]           idx;
    logic [7:0]                 sum;
    logic [NUM_CH-1:0][7:0]     shadow;
    logic [NUM_CH-1:0][7:0]     duty_q;
    logic                       last_byte;

    assign byte_ev   = new_rx_data && !rx_prev;
    assign last_byte = (idx == IDX_W'(NUM_CH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (byte_ev && rx_data == SYNC) state_nxt = ST_PAYLOAD;
            ST_PAYLOAD: if (expired) state_nxt = ST_IDLE;
                        else if (byte_ev && last_byte) state_nxt = ST_CHECK;
            ST_CHECK:   if (expired) state_nxt = ST_IDLE;
                        else if (byte_ev) state_nxt = ST_REPLY;
            ST_REPLY:   if (expired || !tx_busy) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Timer restarts on every byte and on every state change so each phase gets a full window.
    assign tmr_clear = byte_ev || (state_nxt != state);

    byte_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (state != ST_IDLE),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rx_prev     <= 1'b0;
            idx         <= '0;
            sum         <= '0;
            shadow      <= '0;
            duty_q      <= '0;
            duty_valid  <= 1'b0;
            new_tx_data <= 1'b0;
            tx_data     <= '0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            rx_prev     <= new_rx_data;
            state       <= state_nxt;
            duty_valid  <= 1'b0;
            new_tx_data <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_PAYLOAD) begin
                        idx <= '0;
                        sum <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (expired)
                        err_cnt <= sat_inc(err_cnt);
                    else if (byte_ev) begin
                        for (int i = 0; i < NUM_CH; i++)
                            if (idx == IDX_W'(i)) shadow[i] <= rx_data;
                        idx <= idx + 1'b1;
                        sum <= sum + rx_data;
                    end
                end
                ST_CHECK: begin
                    if (expired)
                        err_cnt <= sat_inc(err_cnt);
                    else if (byte_ev) begin
                        if (rx_data == sum) begin
                            duty_q     <= shadow;
                            duty_valid <= 1'b1;
                            frame_cnt  <= sat_inc(frame_cnt);
                            tx_data    <= ACK;
                        end else begin
                            err_cnt    <= sat_inc(err_cnt);
                            tx_data    <= NAK;
                        end
                    end
                end
                ST_REPLY: begin
                    if (expired)
                        err_cnt <= sat_inc(err_cnt);
                    else if (!tx_busy)
                        new_tx_data <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_duty
        assign duty[8*g +: 8] = duty_q[g];
    end

endmodule

// File: tb/tb_pwm_frame_loader.sv
// Directed bench for pwm_frame_loader: commit, NAK, junk, timeout, busy reply, mid-frame reset.
module tb_pwm_frame_loader;
    localparam int NCH = 11;
    localparam int TMO = 200;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [7:0]     rx_data;
    logic           new_rx_data;
    logic           tx_busy;
    logic [7:0]     tx_data;
    logic           new_tx_data;
    logic [NCH*8-1:0] duty;
    logic           duty_valid;
    logic [7:0]     frame_cnt;
    logic [7:0]     err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int dv_cnt  = 0;
    int tx_cnt  = 0;
    int dv0, tx0;

    pwm_frame_loader #(.NUM_CH(NCH), .SYNC(8'hA5), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .duty        (duty),
        .duty_valid  (duty_valid),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (duty_valid)  dv_cnt++;
        if (new_tx_data) tx_cnt++;
    end

    function automatic logic [NCH*8-1:0] exp_duty(input logic [7:0] base, input logic [7:0] step);
        logic [NCH*8-1:0] d;
        for (int i = 0; i < NCH; i++) d[8*i +: 8] = base + step * 8'(i);
        return d;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_data = b; new_rx_data = 1'b1;
        @(negedge clk); new_rx_data = 1'b0;
        @(negedge clk);
    endtask

    // SYNC followed by n payload bytes base, base+step, ...
    task automatic send_payload(input logic [7:0] base, input logic [7:0] step, input int n);
        send_byte(8'hA5);
        for (int i = 0; i < n; i++) send_byte(base + step * 8'(i));
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_data = 8'h00; new_rx_data = 1'b0; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (duty !== '0) begin n_fail++; $display("FAIL reset_duty got %h want 0", duty); end
        n_tests++; if ({frame_cnt, err_cnt, tx_data} !== 24'h0) begin n_fail++;
            $display("FAIL reset_regs got fc=%h ec=%h tx=%h want 0", frame_cnt, err_cnt, tx_data); end
        n_tests++; if ({duty_valid, new_tx_data} !== 2'b00) begin n_fail++;
            $display("FAIL reset_strobes got dv=%b ntx=%b want 0", duty_valid, new_tx_data); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        dv0 = dv_cnt; tx0 = tx_cnt;
        send_payload(8'h01, 8'h01, NCH);
        @(negedge clk); rx_data = 8'h42; new_rx_data = 1'b1;
        @(negedge clk); new_rx_data = 1'b0;
        n_tests++; if (duty_valid !== 1'b1 || duty !== exp_duty(8'h01, 8'h01)) begin n_fail++;
            $display("FAIL good_commit_n1 got dv=%b duty=%h want 1 %h", duty_valid, duty, exp_duty(8'h01, 8'h01)); end
        n_tests++; if (new_tx_data !== 1'b0) begin n_fail++; $display("FAIL good_tx_early got %b want 0", new_tx_data); end
        @(negedge clk);
        n_tests++; if (new_tx_data !== 1'b1 || tx_data !== 8'h06) begin n_fail++;
            $display("FAIL good_ack_n2 got ntx=%b tx=%h want 1 06", new_tx_data, tx_data); end
        repeat (3) @(negedge clk);
        n_tests++; if (dv_cnt - dv0 != 1 || tx_cnt - tx0 != 1) begin n_fail++;
            $display("FAIL good_pulses got dv=%0d tx=%0d want 1 1", dv_cnt - dv0, tx_cnt - tx0); end
        n_tests++; if (frame_cnt !== 8'd1 || err_cnt !== 8'd0) begin n_fail++;
            $display("FAIL good_counts got fc=%0d ec=%0d want 1 0", frame_cnt, err_cnt); end
    endtask

    task automatic test_bad_checksum();
        dv0 = dv_cnt; tx0 = tx_cnt;
        send_payload(8'h01, 8'h01, NCH);
        send_byte(8'h43);
        repeat (3) @(negedge clk);
        n_tests++; if (duty !== exp_duty(8'h01, 8'h01) || dv_cnt != dv0) begin n_fail++;
            $display("FAIL nak_duty got %h dv=%0d want unchanged no pulse", duty, dv_cnt - dv0); end
        n_tests++; if (tx_data !== 8'h15 || tx_cnt - tx0 != 1) begin n_fail++;
            $display("FAIL nak_reply got tx=%h pulses=%0d want 15 1", tx_data, tx_cnt - tx0); end
        n_tests++; if (err_cnt !== 8'd1 || frame_cnt !== 8'd1) begin n_fail++;
            $display("FAIL nak_counts got fc=%0d ec=%0d want 1 1", frame_cnt, err_cnt); end
    endtask

    task automatic test_leading_junk();
        do_reset();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_payload(8'h10, 8'h01, NCH);
        send_byte(8'hE7);
        repeat (3) @(negedge clk);
        n_tests++; if (duty !== exp_duty(8'h10, 8'h01)) begin n_fail++;
            $display("FAIL junk_duty got %h want %h", duty, exp_duty(8'h10, 8'h01)); end
        n_tests++; if (frame_cnt !== 8'd1 || err_cnt !== 8'd0) begin n_fail++;
            $display("FAIL junk_counts got fc=%0d ec=%0d want 1 0", frame_cnt, err_cnt); end
    endtask

    task automatic test_timeout();
        tx0 = tx_cnt;
        send_payload(8'h30, 8'h01, 5);
        repeat (TMO - 10) @(negedge clk);
        n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL tmo_early got ec=%0d want 0", err_cnt); end
        repeat (30) @(negedge clk);
        n_tests++; if (err_cnt !== 8'd1 || tx_cnt != tx0) begin n_fail++;
            $display("FAIL tmo_abort got ec=%0d tx_pulses=%0d want 1 0", err_cnt, tx_cnt - tx0); end
        n_tests++; if (duty !== exp_duty(8'h10, 8'h01)) begin n_fail++;
            $display("FAIL tmo_duty got %h want %h", duty, exp_duty(8'h10, 8'h01)); end
        send_payload(8'h01, 8'h01, NCH);
        send_byte(8'h42);
        repeat (3) @(negedge clk);
        n_tests++; if (duty !== exp_duty(8'h01, 8'h01) || frame_cnt !== 8'd2) begin n_fail++;
            $display("FAIL tmo_recover got duty=%h fc=%0d want %h 2", duty, frame_cnt, exp_duty(8'h01, 8'h01)); end
    endtask

    task automatic test_busy_reply();
        tx0 = tx_cnt;
        tx_busy = 1'b1;
        // every duty byte equals SYNC: 11*A5 mod 256 = 17
        send_payload(8'hA5, 8'h00, NCH);
        @(negedge clk); rx_data = 8'h17; new_rx_data = 1'b1;
        @(negedge clk); new_rx_data = 1'b0;
        n_tests++; if (duty_valid !== 1'b1 || duty !== exp_duty(8'hA5, 8'h00)) begin n_fail++;
            $display("FAIL busy_commit_n1 got dv=%b duty=%h want 1 %h", duty_valid, duty, exp_duty(8'hA5, 8'h00)); end
        send_byte(8'hA5);
        repeat (95) @(negedge clk);
        n_tests++; if (tx_cnt != tx0) begin n_fail++; $display("FAIL busy_hold got pulses=%0d want 0", tx_cnt - tx0); end
        tx_busy = 1'b0;
        @(negedge clk);
        n_tests++; if (new_tx_data !== 1'b1 || tx_data !== 8'h06) begin n_fail++;
            $display("FAIL busy_release got ntx=%b tx=%h want 1 06", new_tx_data, tx_data); end
        @(negedge clk);
        n_tests++; if (new_tx_data !== 1'b0 || tx_cnt - tx0 != 1) begin n_fail++;
            $display("FAIL busy_single got ntx=%b pulses=%0d want 0 1", new_tx_data, tx_cnt - tx0); end
        send_payload(8'h01, 8'h01, NCH);
        send_byte(8'h42);
        repeat (3) @(negedge clk);
        n_tests++; if (duty !== exp_duty(8'h01, 8'h01) || frame_cnt !== 8'd4 || err_cnt !== 8'd1) begin n_fail++;
            $display("FAIL busy_after got duty=%h fc=%0d ec=%0d want A 4 1", duty, frame_cnt, err_cnt); end
    endtask

    task automatic test_reset_midframe();
        send_payload(8'h50, 8'h01, 6);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (duty !== '0 || {frame_cnt, err_cnt, tx_data} !== 24'h0) begin n_fail++;
            $display("FAIL mid_reset got duty=%h fc=%0d ec=%0d tx=%h want 0", duty, frame_cnt, err_cnt, tx_data); end
        rst_n = 1'b1;
        send_payload(8'h01, 8'h01, NCH);
        send_byte(8'h42);
        repeat (3) @(negedge clk);
        n_tests++; if (duty !== exp_duty(8'h01, 8'h01) || frame_cnt !== 8'd1 || err_cnt !== 8'd0) begin n_fail++;
            $display("FAIL mid_recover got duty=%h fc=%0d ec=%0d want A 1 0", duty, frame_cnt, err_cnt); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_leading_junk();
        test_timeout();
        test_busy_reply();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwm_frame_loader.md
PWM_FRAME_LOADER -- requirements
Module: pwm_frame_loader

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 11: number of PWM duty channels carried per frame.
REQ-002 The block SHALL have parameter SYNC, default 8'hA5: frame start byte.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 50000: maximum clk cycles allowed between bytes of a frame, or spent waiting to send a reply (10 ms at 5 MHz).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port rx_data, input, 8 bits: received serial byte.
REQ-007 The block SHALL have port new_rx_data, input, 1 bit: rx_data is valid; qualified by its rising edge.
REQ-008 The block SHALL have port tx_busy, input, 1 bit: the serial transmitter cannot accept a byte.
REQ-009 The block SHALL have port tx_data, output, 8 bits: reply byte.
REQ-010 The block SHALL have port new_tx_data, output, 1 bit: one-cycle strobe launching tx_data.
REQ-011 The block SHALL have port duty, output, NUM_CH*8 bits: committed duty values, channel n in bits [8n+7:8n].
REQ-012 The block SHALL have port duty_valid, output, 1 bit: one-cycle pulse on each commit.
REQ-013 The block SHALL have ports frame_cnt and err_cnt, outputs, 8 bits each: good-frame and error counters.

Function
REQ-014 A byte event SHALL occur only when new_rx_data is high and was low in the previous cycle.
REQ-015 Frame format SHALL be: SYNC, then NUM_CH duty bytes for ch0..ch(NUM_CH-1), then a checksum byte equal to the mod-256 sum of the duty bytes.
REQ-016 The FSM SHALL have four states: IDLE, PAYLOAD, CHECK and REPLY.
REQ-017 IDLE SHALL go to PAYLOAD on a byte event with rx_data==SYNC; all other bytes in IDLE SHALL be discarded silently.
REQ-018 PAYLOAD SHALL store each byte in the shadow register at the current index, add it to the running sum and increment the index; after byte NUM_CH-1 it SHALL go to CHECK.
REQ-019 A SYNC value inside the payload SHALL be treated as data.
REQ-020 In CHECK, on the checksum byte event, a match SHALL copy all shadow registers to duty in one cycle, pulse duty_valid, increment frame_cnt, load tx_data=8'h06 and go to REPLY.
REQ-021 In CHECK, a checksum mismatch SHALL leave duty unchanged, increment err_cnt, load tx_data=8'h15 and go to REPLY.
REQ-022 Commit latency SHALL be exactly 1 cycle: a checksum event in cycle N gives updated duty and duty_valid in cycle N+1.
REQ-023 REPLY SHALL assert new_tx_data for exactly one cycle in the first cycle with tx_busy low (earliest N+2), then go to IDLE.
REQ-024 Byte events in REPLY SHALL be ignored.
REQ-025 A timeout counter SHALL clear on every byte event and on every state entry.
REQ-026 In PAYLOAD, CHECK or REPLY, reaching TIMEOUT_CYC SHALL abort to IDLE, increment err_cnt, send no reply and keep duty unchanged.
REQ-027 The index and running sum SHALL clear on entry to PAYLOAD.
REQ-028 frame_cnt and err_cnt SHALL saturate at 255.

Reset
REQ-029 While rst_n is low at a clock edge, the block SHALL set: state IDLE; duty all zero; duty_valid, new_tx_data, tx_data, frame_cnt and err_cnt zero; shadow registers, index, sum and timer zero; rx edge-detect register zero.
REQ-030 A reset asserted mid-frame SHALL discard the partial frame; the first byte event after release SHALL be parsed from IDLE.

Structure
REQ-031 A shared package SHALL hold the NUM_CH, SYNC, ACK (8'h06), NAK (8'h15) and TIMEOUT_CYC defaults and the FSM state encoding.
REQ-032 The timeout counter SHALL be a sub-module, byte_timer, with inputs clear and enable and output expired.
REQ-033 duty SHALL connect directly to the PWM stage's duty memory.

Verification
REQ-034 Frame A5, 01..0B, 42 with tx_busy=0: duty ch0=01 … ch10=0B, one duty_valid pulse, tx_data=06 with one new_tx_data pulse, frame_cnt=1.
REQ-035 Same frame with checksum 43: duty unchanged, tx_data=15, err_cnt=1, frame_cnt unchanged.
REQ-036 Bytes 00, FF, then a valid frame: leading bytes ignored, frame commits, err_cnt=0.
REQ-037 A5 plus 5 duty bytes, then silence for TIMEOUT_CYC cycles: return to IDLE, err_cnt=1, no new_tx_data; a following valid frame commits.
REQ-038 Valid frame with tx_busy held high for 100 cycles after the checksum: new_tx_data pulses in the first cycle with tx_busy low; duty_valid still occurs at N+1.
REQ-039 rst_n low for 1 cycle after 6 payload bytes, then a full valid frame: outputs zero during reset; the new frame commits correctly.
